// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM geometry, writer FSM states and per-object image tables
package sram_pkg;

    localparam int SRAM_ADDR_COUNT = 20;
    localparam int SRAM_DATA_WIDTH = 16;
    localparam int COLOR_WIDTH     = 4;
    localparam int PIX_CNT_WIDTH   = 20;
    localparam int PIX_PER_WORD    = SRAM_DATA_WIDTH / COLOR_WIDTH;
    localparam int LANE_WIDTH      = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } WriterState;

    // Object regions are laid out back to back: 640x480 map, then two 32x32 car sprites.
    typedef enum logic [1:0] {
        OBJ_MAP,
        OBJ_CAR_RED,
        OBJ_CAR_BLUE
    } ObjId;

    localparam int OBJ_COUNT = 3;

    localparam logic [SRAM_ADDR_COUNT-1:0] OBJ_BASE [OBJ_COUNT] = '{
        20'h00000, 20'h12C00, 20'h12D00
    };

    localparam logic [PIX_CNT_WIDTH-1:0] OBJ_PIXELS [OBJ_COUNT] = '{
        20'd307200, 20'd1024, 20'd1024
    };

endpackage

// File: rtl/sram_word_packer.sv
// rtl/sram_word_packer.sv - gathers encoded colors into one SRAM word, lane 0 in the LSBs
module sram_word_packer
    import sram_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [COLOR_WIDTH-1:0]     i_color,
    output logic [SRAM_DATA_WIDTH-1:0] o_word_next,
    output logic                       o_full
);

    logic [LANE_WIDTH-1:0]      lane_q, lane_d;
    logic [SRAM_DATA_WIDTH-1:0] word_q, word_d;

    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        if (i_clear) begin
            lane_d = '0;
            word_d = '0;
        end else if (i_push) begin
            word_d[lane_q*COLOR_WIDTH +: COLOR_WIDTH] = i_color;
            lane_d = lane_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

    // The word including the pixel being pushed this cycle, so the top can register it directly.
    assign o_word_next = word_d;
    assign o_full      = (lane_q == LANE_WIDTH'(PIX_PER_WORD - 1));

endmodule

// File: rtl/sram_image_writer.sv
// rtl/sram_image_writer.sv - streams encoded pixels into packed SRAM words under arbiter grant
module sram_image_writer
    import sram_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [SRAM_ADDR_COUNT-1:0] i_base_addr,
    input  logic [PIX_CNT_WIDTH-1:0]   i_pixel_count,
    input  logic                       i_pixel_valid,
    input  logic [COLOR_WIDTH-1:0]     i_pixel_color,
    output logic                       o_pixel_ready,
    input  logic                       i_sram_grant,
    output logic [SRAM_ADDR_COUNT-1:0] o_sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] o_sram_wdata,
    output logic                       o_sram_we_n,
    output logic                       o_busy,
    output logic                       o_done
);

    WriterState                 state_q, state_d;
    logic [SRAM_ADDR_COUNT-1:0] base_q, base_d;
    logic [SRAM_ADDR_COUNT-1:0] word_idx_q, word_idx_d;
    logic [PIX_CNT_WIDTH-1:0]   count_q, count_d;
    logic [PIX_CNT_WIDTH-1:0]   pix_cnt_q, pix_cnt_d;
    logic [SRAM_ADDR_COUNT-1:0] addr_q, addr_d;
    logic [SRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                       we_n_q, we_n_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       pk_clear;
    logic                       pk_push;
    logic                       pk_full;
    logic [SRAM_DATA_WIDTH-1:0] pk_word_next;
    logic                       last_pixel;
    logic                       last_word;

    sram_word_packer u_packer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (pk_clear),
        .i_push      (pk_push),
        .i_color     (i_pixel_color),
        .o_word_next (pk_word_next),
        .o_full      (pk_full)
    );

    assign last_pixel = (pix_cnt_q == count_q - 1'b1);
    assign last_word  = (pix_cnt_q == count_q);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        pix_cnt_d  = pix_cnt_q;
        word_idx_d = word_idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_n_d     = 1'b1;
        pk_clear   = 1'b0;
        pk_push    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    base_d     = i_base_addr;
                    count_d    = i_pixel_count;
                    pix_cnt_d  = '0;
                    word_idx_d = '0;
                    pk_clear   = 1'b1;
                    state_d    = (i_pixel_count == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (ready_q && i_pixel_valid) begin
                    pk_push   = 1'b1;
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pk_full || last_pixel) begin
                        addr_d  = base_q + word_idx_q;
                        wdata_d = pk_word_next;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // A low we_n_q means the strobe cycle is the current one; leave on the next edge.
                if (!we_n_q) begin
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        pk_clear   = 1'b1;
                        state_d    = FILL;
                    end
                end else if (i_sram_grant) begin
                    we_n_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == FILL);
        busy_d  = (state_d != IDLE) || (state_q == DONE);
        done_d  = (state_q == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            pix_cnt_q  <= '0;
            word_idx_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_n_q     <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            pix_cnt_q  <= pix_cnt_d;
            word_idx_q <= word_idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_n_q     <= we_n_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_pixel_ready = ready_q;
    assign o_sram_addr   = addr_q;
    assign o_sram_wdata  = wdata_q;
    assign o_sram_we_n   = we_n_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_sram_image_writer.sv
// tb/tb_sram_image_writer.sv - directed and randomized loads checked against a word-packing model
module tb_sram_image_writer;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [19:0] i_base_addr;
    logic [19:0] i_pixel_count;
    logic        i_pixel_valid;
    logic [3:0]  i_pixel_color;
    logic        o_pixel_ready;
    logic        i_sram_grant;
    logic [19:0] o_sram_addr;
    logic [15:0] o_sram_wdata;
    logic        o_sram_we_n;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_err    = 0;

    logic [3:0]  colors[$];
    logic [19:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic [19:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          hs_cnt;
    int          done_cnt;
    int          busy_gaps;
    bit          in_load = 1'b0;

    sram_image_writer dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_base_addr   (i_base_addr),
        .i_pixel_count (i_pixel_count),
        .i_pixel_valid (i_pixel_valid),
        .i_pixel_color (i_pixel_color),
        .o_pixel_ready (o_pixel_ready),
        .i_sram_grant  (i_sram_grant),
        .o_sram_addr   (o_sram_addr),
        .o_sram_wdata  (o_sram_wdata),
        .o_sram_we_n   (o_sram_we_n),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_sram_we_n === 1'b0) begin
            wr_addr.push_back(o_sram_addr);
            wr_data.push_back(o_sram_wdata);
        end
        if (o_pixel_ready && i_pixel_valid && !i_rst) hs_cnt++;
        if (o_done) done_cnt++;
        if (in_load && !o_busy) busy_gaps++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel p lands in word p/4, nibble p%4; words sit at consecutive wrapping addresses.
    task automatic build_model(input logic [19:0] base, input int cnt);
        int nwords;
        exp_addr.delete();
        exp_data.delete();
        nwords = (cnt + 3) / 4;
        for (int w = 0; w < nwords; w++) begin
            int data = 0;
            for (int l = 0; l < 4; l++) begin
                if (w * 4 + l < cnt) data += int'(colors[w * 4 + l]) * (1 << (4 * l));
            end
            exp_addr.push_back(20'((int'(base) + w) % (1 << 20)));
            exp_data.push_back(16'(data));
        end
    endtask

    task automatic clear_monitors();
        wr_addr.delete();
        wr_data.delete();
        hs_cnt    = 0;
        done_cnt  = 0;
        busy_gaps = 0;
    endtask

    task automatic pulse_start(input logic [19:0] base, input logic [19:0] cnt);
        i_start       = 1'b1;
        i_base_addr   = base;
        i_pixel_count = cnt;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic feed_pixel(input string name, input logic [3:0] c, input int gap_max);
        bit hs = 1'b0;
        int g  = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        for (int k = 0; k < g; k++) begin
            i_pixel_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        i_pixel_valid = 1'b1;
        i_pixel_color = c;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_pixel_ready) hs = 1'b1;
            @(posedge clk);
            #1;
            if (hs) break;
        end
        i_pixel_valid = 1'b0;
        if (!hs) check($sformatf("%s.handshake_timeout", name), 32'(hs), 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (o_done) got = 1'b1;
            @(posedge clk);
            #1;
            if (got) break;
        end
        check($sformatf("%s.done_seen", name), 32'(got), 32'd1);
    endtask

    task automatic compare_writes(input string name);
        int n = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
        check($sformatf("%s.write_count", name), 32'(wr_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.addr[%0d]", name, i), 32'(wr_addr[i]), 32'(exp_addr[i]));
            check($sformatf("%s.wdata[%0d]", name, i), 32'(wr_data[i]), 32'(exp_data[i]));
        end
    endtask

    task automatic run_load(input string name, input logic [19:0] base, input int cnt,
                            input int gap_max, input int mid_start_at, input int hold);
        clear_monitors();
        build_model(base, cnt);
        if (hold > 0) i_sram_grant = 1'b0;
        pulse_start(base, 20'(cnt));
        in_load = 1'b1;
        for (int p = 0; p < cnt; p++) begin
            if (p == mid_start_at) pulse_start(20'h55555, 20'd3);
            feed_pixel(name, colors[p], gap_max);
        end
        if (hold > 0) begin
            int bad = 0;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (o_sram_we_n !== 1'b1 || o_pixel_ready !== 1'b0 ||
                    o_sram_addr !== exp_addr[0] || o_sram_wdata !== exp_data[0]) bad++;
                @(posedge clk);
                #1;
            end
            check($sformatf("%s.hold_stable", name), 32'(bad), 32'd0);
            check($sformatf("%s.no_write_while_denied", name), 32'(wr_addr.size()), 32'd0);
            i_sram_grant = 1'b1;
        end
        wait_done(name);
        in_load = 1'b0;
        @(posedge clk);
        #1;
        compare_writes(name);
        check($sformatf("%s.handshakes", name), 32'(hs_cnt), 32'(cnt));
        check($sformatf("%s.done_pulses", name), 32'(done_cnt), 32'd1);
        check($sformatf("%s.busy_gaps", name), 32'(busy_gaps), 32'd0);
    endtask

    task automatic random_colors(input int cnt);
        colors.delete();
        for (int i = 0; i < cnt; i++) colors.push_back(4'($urandom_range(0, 15)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst         = 1'b1;
        i_start       = 1'b0;
        i_base_addr   = '0;
        i_pixel_count = '0;
        i_pixel_valid = 1'b0;
        i_pixel_color = '0;
        i_sram_grant  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.addr",  32'(o_sram_addr),   32'd0);
        check("reset.wdata", 32'(o_sram_wdata),  32'd0);
        check("reset.we_n",  32'(o_sram_we_n),   32'd1);
        check("reset.ready", 32'(o_pixel_ready), 32'd0);
        check("reset.busy",  32'(o_busy),        32'd0);
        check("reset.done",  32'(o_done),        32'd0);
        i_rst = 1'b0;
        @(posedge clk);
        #1;

        colors = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        run_load("seq8", 20'h01000, 8, 0, -1, 0);
        if (wr_data.size() == 2) begin
            check("seq8.const_w0", 32'(wr_data[0]), 32'h4321);
            check("seq8.const_w1", 32'(wr_data[1]), 32'h8765);
        end

        colors = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        run_load("partial6", 20'h02000, 6, 0, -1, 0);
        if (wr_data.size() == 2) begin
            check("partial6.const_w0", 32'(wr_data[0]), 32'hDCBA);
            check("partial6.const_w1", 32'(wr_data[1]), 32'h00FE);
        end

        random_colors(4);
        run_load("grant_hold", 20'h02800, 4, 0, -1, 10);

        random_colors(12);
        run_load("gapfree12", 20'h03000, 12, 0, -1, 0);
        run_load("gaps12", 20'h03000, 12, 3, 6, 0);

        random_colors(7);
        run_load("wrap7", 20'hFFFFF, 7, 2, -1, 0);

        random_colors(1);
        run_load("single1", 20'h07000, 1, 1, -1, 0);

        // Reset after five pixels: the first full word is already in SRAM, the partial one is dropped.
        random_colors(16);
        build_model(20'h04000, 16);
        clear_monitors();
        pulse_start(20'h04000, 20'd16);
        for (int p = 0; p < 5; p++) feed_pixel("rst_mid", colors[p], 0);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid.addr",  32'(o_sram_addr),   32'd0);
        check("rst_mid.wdata", 32'(o_sram_wdata),  32'd0);
        check("rst_mid.we_n",  32'(o_sram_we_n),   32'd1);
        check("rst_mid.ready", 32'(o_pixel_ready), 32'd0);
        check("rst_mid.busy",  32'(o_busy),        32'd0);
        check("rst_mid.done",  32'(o_done),        32'd0);
        check("rst_mid.writes_before", 32'(wr_addr.size()), 32'd1);
        if (wr_data.size() >= 1) check("rst_mid.w0", 32'(wr_data[0]), 32'(exp_data[0]));
        i_rst = 1'b0;
        @(posedge clk);
        #1;
        random_colors(4);
        run_load("after_rst", 20'h05000, 4, 1, -1, 0);

        clear_monitors();
        pulse_start(20'h06000, 20'd0);
        check("zero.done_e1", 32'(o_done), 32'd0);
        check("zero.busy_e1", 32'(o_busy), 32'd1);
        @(posedge clk);
        #1;
        check("zero.done_e2", 32'(o_done), 32'd1);
        check("zero.busy_e2", 32'(o_busy), 32'd1);
        @(posedge clk);
        #1;
        check("zero.done_e3", 32'(o_done), 32'd0);
        check("zero.busy_e3", 32'(o_busy), 32'd0);
        check("zero.writes", 32'(wr_addr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
